// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - start/busy/done handshake and HI/LO result bundle for the iterative multiply/divide unit
// MDU_DIV0_FLAG_EN adds the div0 result flag.
interface mdu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       MDUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
  logic             div0;
`endif

  modport master (
    output start, MDUOp, A, B,
`ifdef MDU_DIV0_FLAG_EN
    input  div0,
`endif
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, MDUOp, A, B,
`ifdef MDU_DIV0_FLAG_EN
    output div0,
`endif
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers
// MDU_DIV0_FLAG_EN: optional div0 flag raised in the done cycle of a divide by zero.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic       clk,
  input logic       rst,
  mdu_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               is_mul;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               op_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul_nx;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   quo_nx;
  logic [WIDTH-1:0]   rem_nx;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;

  always_comb begin
    op_signed = ~bus.MDUOp[0];
    abs_a     = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    abs_b     = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Multiply: low half of acc holds the remaining multiplier bits, upper half the partial product.
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    acc_mul_nx = {mul_sum, acc[WIDTH-1:1]};

    // Divide: low half of acc shifts dividend bits out and quotient bits in.
    div_sh   = {rem, acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb};
    quo_nx   = {acc[WIDTH-2:0], ~div_diff[WIDTH]};
    rem_nx   = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];

    prod_fin = neg_q ? -acc_mul_nx : acc_mul_nx;
    quo_fin  = dz ? '1 : (neg_q ? -quo_nx : quo_nx);
    rem_fin  = neg_r ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      is_mul   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      opb      <= '0;
      acc      <= '0;
      rem      <= '0;
`ifdef MDU_DIV0_FLAG_EN
      bus.div0 <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            case (bus.MDUOp)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                state    <= S_RUN;
                count    <= '0;
                bus.busy <= 1'b1;
                is_mul   <= ~bus.MDUOp[1];
                neg_q    <= op_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                neg_r    <= op_signed & bus.A[WIDTH-1];
                dz       <= (bus.B == '0);
                opb      <= abs_b;
                acc      <= {{WIDTH{1'b0}}, abs_a};
                rem      <= '0;
`ifdef MDU_DIV0_FLAG_EN
                bus.div0 <= 1'b0;
`endif
              end
              3'b100: begin
                bus.hi   <= bus.A;
                bus.done <= 1'b1;
              end
              3'b101: begin
                bus.lo   <= bus.A;
                bus.done <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        S_RUN: begin
          count <= count + CNT_W'(1);
          if (is_mul) begin
            acc <= acc_mul_nx;
          end else begin
            acc <= {{WIDTH{1'b0}}, quo_nx};
            rem <= rem_nx;
          end
          // Final iteration and sign fix-up land together so hi/lo are valid while done is high.
          if (count == CNT_W'(WIDTH-1)) begin
            state    <= S_FIN;
            bus.done <= 1'b1;
            if (is_mul) begin
              bus.hi <= prod_fin[2*WIDTH-1:WIDTH];
              bus.lo <= prod_fin[WIDTH-1:0];
            end else begin
              bus.hi <= rem_fin;
              bus.lo <= quo_fin;
            end
`ifdef MDU_DIV0_FLAG_EN
            bus.div0 <= dz & ~is_mul;
`endif
          end
        end

        S_FIN: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
          bus.div0 <= 1'b0;
`endif
        end

        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq against an arithmetic reference model
module tb_mdu_seq;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mdu_seq_if #(.WIDTH(32)) mif ();

  mdu_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    int                 sa;
    int                 sb;
    sa = a;
    sb = b;
    eh = '0;
    el = '0;
    case (op)
      3'd0: begin
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {eh, el} = ps;
      end
      3'd1: begin
        pu = {32'h0, a} * {32'h0, b};
        {eh, el} = pu;
      end
      3'd2: begin
        if (b == 0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'h0;
        end else begin
          el = sa / sb;
          eh = sa % sb;
        end
      end
      default: begin
        if (b == 0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  // Issues one request and follows it until busy drops; reports observed handshake and results.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cnt, output int done_cnt, output int div0_cnt,
                       output logic [31:0] got_hi, output logic [31:0] got_lo, output bit timeout);
    int n;
    busy_cnt = 0;
    done_cnt = 0;
    div0_cnt = 0;
    got_hi   = 'x;
    got_lo   = 'x;
    timeout  = 1'b0;
    @(posedge clk);
    #1;
    mif.start = 1'b1;
    mif.MDUOp = op;
    mif.A     = a;
    mif.B     = b;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.A     = $urandom;
    mif.B     = $urandom;
    n = 0;
    while (n < 100) begin
      if (mif.busy) busy_cnt++;
      if (mif.done) begin
        done_cnt++;
        got_hi = mif.hi;
        got_lo = mif.lo;
      end
`ifdef MDU_DIV0_FLAG_EN
      if (mif.div0) div0_cnt++;
`endif
      if (!mif.busy) break;
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.hi !== 32'h0 || mif.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", mif.busy, mif.done, mif.hi, mif.lo);
    end
  endtask

  task automatic test_mult_basic();
    int bc, dc, zc;
    logic [31:0] h, l;
    bit to;
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, bc, dc, zc, h, l, to);
    checks++;
    if (to || bc !== 33) begin
      errors++;
      $display("FAIL mult_latency: busy cycles=%0d timeout=%0d, want 33", bc, to);
    end
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL mult_done_pulse: done cycles=%0d, want 1", dc);
    end
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg3x7: hi=%h lo=%h, want ffffffff ffffffeb", h, l);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [6]  = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3};
    logic [31:0] as_ [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd100};
    logic [31:0] bs_ [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] eh_ [6] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'd100};
    logic [31:0] el_ [6] = '{32'h1, 32'h1, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF};
    int bc, dc, zc;
    logic [31:0] h, l;
    bit to;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], as_[i], bs_[i], bc, dc, zc, h, l, to);
      checks++;
      if (to || dc !== 1 || bc !== 33 || h !== eh_[i] || l !== el_[i]) begin
        errors++;
        $display("FAIL directed_%0d: hi=%h lo=%h busy=%0d done=%0d, want %h %h 33 1",
                 i, h, l, bc, dc, eh_[i], el_[i]);
      end
`ifdef MDU_DIV0_FLAG_EN
      checks++;
      if (zc !== ((i == 5) ? 1 : 0)) begin
        errors++;
        $display("FAIL div0_flag_%0d: div0 cycles=%0d, want %0d", i, zc, (i == 5) ? 1 : 0);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, eh, el, h, l;
    int bc, dc, zc;
    bit to;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 20));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      model(op, a, b, eh, el);
      do_op(op, a, b, bc, dc, zc, h, l, to);
      checks++;
      if (to || dc !== 1 || h !== eh || l !== el) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h done=%0d, want %h %h 1",
                 i, op, a, b, h, l, dc, eh, el);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    int bc, dc, zc;
    logic [31:0] h, l, lo_before;
    bit to;
    lo_before = mif.lo;
    do_op(3'd4, 32'h1234_5678, 32'h0, bc, dc, zc, h, l, to);
    checks++;
    if (bc !== 0 || dc !== 1 || mif.hi !== 32'h1234_5678 || mif.lo !== lo_before) begin
      errors++;
      $display("FAIL mthi: busy=%0d done=%0d hi=%h lo=%h, want 0 1 12345678 %h", bc, dc, mif.hi, mif.lo, lo_before);
    end
    do_op(3'd5, 32'h9ABC_DEF0, 32'h0, bc, dc, zc, h, l, to);
    checks++;
    if (bc !== 0 || dc !== 1 || mif.hi !== 32'h1234_5678 || mif.lo !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL mtlo: busy=%0d done=%0d hi=%h lo=%h, want 0 1 12345678 9abcdef0", bc, dc, mif.hi, mif.lo);
    end
    // Undefined opcode: no done, no register change.
    do_op(3'd6, 32'h5555_5555, 32'h1, bc, dc, zc, h, l, to);
    checks++;
    if (bc !== 0 || dc !== 0 || mif.hi !== 32'h1234_5678 || mif.lo !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL undefined_op: busy=%0d done=%0d hi=%h lo=%h", bc, dc, mif.hi, mif.lo);
    end
  endtask

  task automatic test_ignore_while_busy();
    int n;
    int bad_hold;
    int dc;
    logic [31:0] h, l;
    bad_hold = 0;
    dc = 0;
    h = 'x;
    l = 'x;
    @(posedge clk);
    #1;
    mif.start = 1'b1;
    mif.MDUOp = 3'd1;
    mif.A     = 32'd1000;
    mif.B     = 32'd3000;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    n = 0;
    while (n < 100) begin
      if (n == 5) begin
        mif.start = 1'b1;
        mif.MDUOp = 3'd4;
        mif.A     = 32'hDEAD_BEEF;
      end else begin
        mif.start = 1'b0;
      end
      if (mif.done) begin
        dc++;
        h = mif.hi;
        l = mif.lo;
      end else if (mif.busy && (mif.hi !== 32'h1234_5678 || mif.lo !== 32'h9ABC_DEF0)) begin
        bad_hold++;
      end
      if (!mif.busy) break;
      @(posedge clk);
      #1;
      n++;
    end
    mif.start = 1'b0;
    checks++;
    if (bad_hold !== 0) begin
      errors++;
      $display("FAIL hold_during_run: %0d cycles with changed hi/lo, want 0", bad_hold);
    end
    checks++;
    if (n >= 100 || dc !== 1 || h !== 32'h0 || l !== 32'd3_000_000) begin
      errors++;
      $display("FAIL ignore_busy_start: hi=%h lo=%h done=%0d, want 0 002dc6c0 1", h, l, dc);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mif.hi !== 32'h0 || mif.done !== 1'b0) begin
      errors++;
      $display("FAIL not_queued: hi=%h done=%b, want 0 0", mif.hi, mif.done);
    end
  endtask

  task automatic test_reset_mid_op();
    int bc, dc, zc, late_done;
    logic [31:0] h, l;
    bit to;
    @(posedge clk);
    #1;
    mif.start = 1'b1;
    mif.MDUOp = 3'd2;
    mif.A     = 32'd1234;
    mif.B     = 32'd5;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.hi !== 32'h0 || mif.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", mif.busy, mif.done, mif.hi, mif.lo);
    end
    late_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (mif.done || mif.busy) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      errors++;
      $display("FAIL reset_discard: %0d cycles busy/done after reset, want 0", late_done);
    end
    do_op(3'd0, 32'd6, 32'd7, bc, dc, zc, h, l, to);
    checks++;
    if (to || dc !== 1 || h !== 32'h0 || l !== 32'd42) begin
      errors++;
      $display("FAIL mult_after_reset: hi=%h lo=%h done=%0d, want 0 0000002a 1", h, l, dc);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    mif.start = 1'b0;
    mif.MDUOp = 3'd0;
    mif.A     = '0;
    mif.B     = '0;
    test_reset();
    test_mult_basic();
    test_directed();
    test_random();
    test_mthi_mtlo();
    test_ignore_while_busy();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Iterative multiply/divide unit, the multi-cycle companion to the single-cycle ALU in the execute stage. Handles MULT/MULTU/DIV/DIVU and MTHI/MTLO, which the ALU does not. Uses a start/busy/done handshake toward the controller. Results land in architectural HI/LO registers, read directly by the datapath for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; accepted only when busy=0
MDUOp  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
A  in  WIDTH  operand A / dividend / MTHI-MTLO source
B  in  WIDTH  operand B / divisor
busy  out  1  iteration in progress
done  out  1  one-cycle pulse, HI/LO just updated
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high.
- Reset, including mid-operation: state=IDLE, count=0, busy=0, done=0, hi=0, lo=0. Any in-flight operation is discarded.
- States:
  - IDLE: waits for start.
  - RUN: one iteration per cycle.
  - FIN: writes HI/LO and pulses done.
- Accept edge: start=1 in IDLE with MDUOp 000-011.
  - Latch |A| and |B| (signed ops) or raw A and B (unsigned ops).
  - Record the result sign(s).
  - count=0, go to RUN.
- RUN:
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient/remainder kept in internal registers.
  - Advance count each cycle. At count==WIDTH-1 go to FIN.
- FIN (1 cycle):
  - Apply sign correction (two's-complement negate where needed).
  - Write hi/lo; done=1 for this cycle.
  - Return to IDLE.
- Timing: busy=1 in RUN and FIN, i.e. WIDTH+1 cycles after accept. New hi/lo are visible on the cycle done=1. Back-to-back start is possible on the cycle after done.
- hi/lo hold their previous values throughout RUN. Internal accumulators are separate from hi/lo.
- start while busy=1 is ignored; it is not queued.
- MTHI/MTLO accepted in IDLE:
  - hi (or lo) <= A on the accept edge.
  - No busy; done=1 on the following cycle.
  - Other register unchanged.
- Undefined MDUOp with start: no state change, no done.
- MULT: {hi,lo} = signed 64-bit product.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, sign follows the dividend.
- Divide by zero (B=0): lo=all ones, hi=A; still takes full latency.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are sampled only on the accept edge; A/B may change freely during RUN.

Optional Feature:
Macro MDU_DIV0_FLAG_EN.
- Defined: adds output port div0 (1 bit), reset 0.
  - div0=1 in the done cycle of a DIV/DIVU with B=0; otherwise 0.
  - Cleared on the next accept.
  - Result values unchanged.
- Not defined: port and logic absent; divide-by-zero only produces the defined hi/lo values.

Test Plan:
1. Reset, MULT A=0xFFFFFFFD (-3), B=7 -> busy high 33 cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT same operands -> hi=0, lo=1.
3. DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=100, B=7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU A=100, B=0 -> lo=0xFFFFFFFF, hi=100. With MDU_DIV0_FLAG_EN, div0=1 for exactly the done cycle.
5. MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 -> hi/lo take those values on the accept edges, busy never asserts. During a MULT, pulse start with MTHI -> ignored. Old hi visible until done, then product.
6. Start DIV, assert rst at cycle 10 -> next cycle busy=0, hi=lo=0, no done. A fresh MULT 6*7 then completes with lo=42.
